// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
// Address layout, master IDs, FSM encoding and grant-selection helpers.
package sdram_pkg;

   localparam int NUM_M       = 3;
   localparam int ROW_W       = 13;
   localparam int BANK_W      = 2;
   localparam int COL_W       = 9;
   localparam int ADDR_W      = ROW_W + BANK_W + COL_W + 2;
   localparam int DATA_W      = 32;
   localparam int BE_W        = 4;
   localparam int BURST_WORDS = 16;

   localparam logic [2:0] MASTER0 = 3'b001;
   localparam logic [2:0] MASTER1 = 3'b010;
   localparam logic [2:0] MASTER2 = 3'b100;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT      = 2'd1,
      WAIT_BURST = 2'd2
   } arb_state_t;

   // First requester after the last granted master, wrapping 2 -> 0.
   function automatic logic [2:0] rr_pick(
      input logic [2:0] req,
      input logic [2:0] last
   );
      logic [2:0] g;
      g = 3'b000;
      unique case (last)
         MASTER0: begin
            if (req[1])      g = MASTER1;
            else if (req[2]) g = MASTER2;
            else if (req[0]) g = MASTER0;
         end
         MASTER1: begin
            if (req[2])      g = MASTER2;
            else if (req[0]) g = MASTER0;
            else if (req[1]) g = MASTER1;
         end
         default: begin
            if (req[0])      g = MASTER0;
            else if (req[1]) g = MASTER1;
            else if (req[2]) g = MASTER2;
         end
      endcase
      return g;
   endfunction

   // Master 0 always wins, then 1, then 2.
   function automatic logic [2:0] fp_pick(input logic [2:0] req);
      logic [2:0] g;
      g = 3'b000;
      if (req[0])      g = MASTER0;
      else if (req[1]) g = MASTER1;
      else if (req[2]) g = MASTER2;
      return g;
   endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Master-side and controller-side buses of the SDRAM arbiter.
// slave: the arbiter's view; master: the requesters plus controller.
interface sdram_arbiter_if;
   import sdram_pkg::*;

   logic [NUM_M-1:0]             m_req;
   logic [NUM_M-1:0][ADDR_W-1:0] m_addr;
   logic [NUM_M-1:0]             m_write;
   logic [NUM_M-1:0]             m_burst;
   logic [NUM_M-1:0][BE_W-1:0]   m_byte_enable;
   logic [NUM_M-1:0][DATA_W-1:0] m_wdata;
   logic [NUM_M-1:0]             m_ack;
   logic [DATA_W-1:0]            m_rdata;
   logic [NUM_M-1:0]             m_rdvalid;
   logic [NUM_M-1:0]             m_complete;

   logic [NUM_M-1:0]             sdram_req;
   logic [ADDR_W-1:0]            sdram_addr;
   logic                         sdram_write;
   logic                         sdram_burst;
   logic [BE_W-1:0]              sdram_byte_enable;
   logic [DATA_W-1:0]            sdram_wdata;
   logic                         sdram_ack;
   logic [DATA_W-1:0]            sdram_rdata;
   logic [NUM_M-1:0]             sdram_rdvalid;
   logic                         sdram_complete;

   modport slave (
      input  m_req, m_addr, m_write, m_burst, m_byte_enable, m_wdata,
      output m_ack, m_rdata, m_rdvalid, m_complete,
      output sdram_req, sdram_addr, sdram_write, sdram_burst,
      output sdram_byte_enable, sdram_wdata,
      input  sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
   );

   modport master (
      output m_req, m_addr, m_write, m_burst, m_byte_enable, m_wdata,
      input  m_ack, m_rdata, m_rdvalid, m_complete,
      input  sdram_req, sdram_addr, sdram_write, sdram_burst,
      input  sdram_byte_enable, sdram_wdata,
      output sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
   );

endinterface

// File: rtl/sdram_arb_idq.sv
// In-order queue of one-hot master IDs for outstanding reads.
// Extra pointer bit separates full from empty; push+pop at full is honoured.
module sdram_arb_idq #(
   parameter  int QDEPTH = 4,
   localparam int PW     = $clog2(QDEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push_i,
   input  logic [2:0]    din_i,
   input  logic          pop_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [2:0]    head_o,
   output logic [PW-1:0] count_o
);

   logic [2:0]    mem_q [QDEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[PW-1] != rd_q[PW-1]) &&
                    (wr_q[PW-2:0] == rd_q[PW-2:0]);
   assign count_o = wr_q - rd_q;
   assign head_o  = mem_q[rd_q[PW-2:0]];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Pointer advance on accepted push / pop.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
   end

   // Pointer registers; reset empties the queue.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: pointers define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_q[PW-2:0]] <= din_i;
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-master round-robin arbiter in front of the SDRAM controller.
// Build option SDRAM_ARB_FIXED_PRIORITY_EN selects fixed priority (0 > 1 > 2).
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int QDEPTH      = 4
) (
   input logic             clock,
   input logic             reset,
   sdram_arbiter_if.slave  bus
);

   localparam int         PW           = $clog2(QDEPTH) + 1;
   localparam logic [1:0] S_IDLE       = IDLE;
   localparam logic [1:0] S_GRANT      = GRANT;
   localparam logic [1:0] S_WAIT_BURST = WAIT_BURST;

   logic [1:0]             state_q, state_d;
   logic [2:0]             grant_q, grant_d;
   logic [PW-1:0]          brem_q, brem_d;
   logic [2:0]             mcmp_q, mcmp_d;

   logic [NUM_MASTERS-1:0] elig;
   logic [2:0]             pick;
   logic                   in_grant;
   logic                   ack_ev;
   logic                   q_push;
   logic                   q_pop;
   logic                   q_full;
   logic                   q_empty;
   logic [2:0]             q_head;
   logic [PW-1:0]          q_count;

   logic [ADDR_W-1:0]      sel_addr;
   logic                   sel_write;
   logic                   sel_burst;
   logic [BE_W-1:0]        sel_be;
   logic [DATA_W-1:0]      sel_wdata;

   assign in_grant = (state_q == S_GRANT);
   assign ack_ev   = in_grant & bus.sdram_ack;
   assign q_push   = ack_ev & ~sel_write;
   assign q_pop    = bus.sdram_complete & ~q_empty;
   assign elig     = bus.m_req &
                     (bus.m_write | {NUM_MASTERS{~q_full}});

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
   assign pick = fp_pick(elig);
`else
   logic [2:0] last_grant_q, last_grant_d;

   // Remember the most recently acknowledged master.
   always_comb begin
      last_grant_d = last_grant_q;
      if (ack_ev) last_grant_d = grant_q;
   end

   // Start with master 2 as last so master 0 wins first.
   always_ff @(posedge clock) begin
      if (reset) last_grant_q <= MASTER2;
      else       last_grant_q <= last_grant_d;
   end

   assign pick = rr_pick(elig, last_grant_q);
`endif

   // Mux the granted master's fields onto the controller bus.
   always_comb begin
      sel_addr  = '0;
      sel_write = 1'b0;
      sel_burst = 1'b0;
      sel_be    = '0;
      sel_wdata = '0;
      if (in_grant) begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
               sel_addr  = bus.m_addr[i];
               sel_write = bus.m_write[i];
               sel_burst = bus.m_burst[i];
               sel_be    = bus.m_byte_enable[i];
               sel_wdata = bus.m_wdata[i];
            end
         end
      end
   end

   // Arbitration FSM; a burst waits until its own queue entry pops.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      brem_d  = brem_q;
      if (q_pop && brem_q != '0) brem_d = brem_q - PW'(1);
      unique case (state_q)
         S_IDLE: begin
            if (|elig) begin
               grant_d = pick;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (bus.sdram_ack) begin
               if (!sel_write && sel_burst) begin
                  state_d = S_WAIT_BURST;
                  brem_d  = q_count + PW'(1) - PW'(q_pop);
               end else begin
                  state_d = S_IDLE;
                  grant_d = '0;
               end
            end
         end
         S_WAIT_BURST: begin
            if (q_pop && brem_q == PW'(1)) begin
               state_d = S_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Completion pulse is attributed to the queue head.
   always_comb begin
      mcmp_d = '0;
      if (q_pop) mcmp_d = q_head;
   end

   // State registers; reset aborts any grant or burst.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         brem_q  <= '0;
         mcmp_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         brem_q  <= brem_d;
         mcmp_q  <= mcmp_d;
      end
   end

   sdram_arb_idq #(
      .QDEPTH (QDEPTH)
   ) u_idq (
      .clock   (clock),
      .reset   (reset),
      .push_i  (q_push),
      .din_i   (grant_q),
      .pop_i   (q_pop),
      .full_o  (q_full),
      .empty_o (q_empty),
      .head_o  (q_head),
      .count_o (q_count)
   );

   assign bus.sdram_req         = in_grant ? grant_q : '0;
   assign bus.sdram_addr        = sel_addr;
   assign bus.sdram_write       = sel_write;
   assign bus.sdram_burst       = sel_burst;
   assign bus.sdram_byte_enable = sel_be;
   assign bus.sdram_wdata       = sel_wdata;

   assign bus.m_ack      = ack_ev ? grant_q : '0;
   assign bus.m_complete = mcmp_q;
   assign bus.m_rdata    = bus.sdram_rdata;
   assign bus.m_rdvalid  = bus.sdram_rdvalid;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-master arbiter sitting directly upstream of the SDRAM controller. Selects one pending master request by round-robin, presents it on the controller's request bus until the controller acknowledges it, and routes acknowledge, read data, per-master read-valid and per-master burst-complete back. An in-order ID queue attributes the controller's untagged `sdram_complete` pulses to the master that issued the read.

## Interface
- `NUM_MASTERS`, 3: masters served; fixed at 3 to match the one-hot 3-bit `sdram_req`.
- `QDEPTH`, 4: outstanding-read ID queue depth; must be a power of two.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `m_req`  in  3  per-master request; held until the matching `m_ack`.
- `m_addr`  in  3×26  byte address per master.
- `m_write`  in  3  per master: 1 = write.
- `m_burst`  in  3  per master: 1 = 16-word burst read.
- `m_byte_enable`  in  3×4  write byte enables.
- `m_wdata`  in  3×32  write data.
- `m_ack`  out  3  one-hot acknowledge.
- `m_rdata`  out  32  broadcast read data (`sdram_rdata`).
- `m_rdvalid`  out  3  `sdram_rdvalid`, passed through.
- `m_complete`  out  3  one-cycle pulse when that master's read (single or burst) is finished.
- `sdram_req`  out  3  one-hot granted master; 0 when idle.
- `sdram_addr`, `sdram_write`, `sdram_burst`, `sdram_byte_enable`, `sdram_wdata`  out  26/1/1/4/32  muxed from the granted master; 0 when idle.
- `sdram_ack`, `sdram_rdata`, `sdram_rdvalid`, `sdram_complete`  in  1/32/3/1  from the controller.

## Operation
- States: IDLE, GRANT, WAIT_BURST.
- IDLE:
  - An eligible master has `m_req`=1. Reads are ineligible while the queue is full.
  - Pick the first eligible master after `last_grant`, wrapping 2→0.
  - Register its one-hot code in `grant` and go to GRANT.
- GRANT:
  - Drive `sdram_req`=`grant` and mux that master's fields onto the controller bus.
  - Route `m_ack` = `grant` & {3{`sdram_ack`}} combinationally.
  - On `sdram_ack`: set `last_grant`=`grant`. A read pushes `grant` into the queue.
  - After the ack, a burst read goes to WAIT_BURST; anything else goes to IDLE.
- WAIT_BURST:
  - `sdram_req`=0.
  - On a `sdram_complete` that pops this burst's entry, go to IDLE.
- ID queue:
  - `sdram_complete` pops the head and pulses `m_complete[head]`.
  - A push and a pop in the same cycle are both honoured, including when the queue is full.
  - `sdram_complete` with the queue empty is ignored and raises no pulse.
- Writes never enter the queue and produce no `m_complete`.
- Masters must hold `m_req` and all fields stable from assertion until `m_ack`. Dropping `m_req` early is a protocol violation; the bench checks it with an assertion.
- Reset values:
  - state IDLE, `grant`=0, `last_grant`=master 2 (so master 0 wins first), queue empty.
  - All of `sdram_*` outputs 0, and `m_ack`, `m_complete`, `m_rdvalid` 0.
- Reset mid-burst or mid-grant aborts immediately and clears the queue. The controller is reset by the same signal.

## Timing
- `m_req` first seen in cycle N (IDLE): `sdram_req` is valid from N+1.
- `m_ack` is coincident with `sdram_ack`, earliest N+1.
- After a non-burst ack in cycle K: IDLE at K+1, next `sdram_req` at K+2 at the earliest.
- `m_complete` is registered: it appears one cycle after `sdram_complete`.
- `m_rdvalid` and `m_rdata` have zero added latency.

## Configuration
- `SDRAM_ARB_FIXED_PRIORITY_EN` defined: fixed priority, master 0 highest, then 1, then 2. `last_grant` is not implemented.
- Undefined (default): round-robin as described in Operation.

## Structure
- Shared package `sdram_pkg` holds:
  - `arb_state_t` (IDLE/GRANT/WAIT_BURST).
  - One-hot master ID constants `MASTER0..2`.
  - Address field widths: row 13, bank 2, column 9.
  - `BURST_WORDS`=16.
- Sub-module `sdram_arb_idq`: synchronous FIFO of 3-bit IDs with push, pop, full, empty and `head`.
  - Pointers are `$clog2(QDEPTH)`+1 bits so full and empty can be distinguished.

## Test plan
- Master 1 single read at 0x0000100, `sdram_ack` in the next cycle → `sdram_req`=3'b010 one cycle after request, `m_ack`=3'b010 for one cycle; `sdram_complete` 4 cycles later → `m_complete`=3'b010 one cycle after that.
- All three masters request writes continuously → grants 001, 010, 100, 001 in rotation, no master acked twice in a row.
- Master 0 burst read at 0x0002000 while master 2 requests → master 2 is not granted until cycle after `sdram_complete` clears WAIT_BURST.
- Four single reads acked, no completes → fifth read withheld while write from master 1 is still granted; one `sdram_complete` → read granted next IDLE.
- Reset asserted in WAIT_BURST with two queued IDs → next cycle all outputs 0, queue empty, later `sdram_complete` produces no `m_complete`.
- With `SDRAM_ARB_FIXED_PRIORITY_EN`, masters 0 and 2 requesting writes continuously → master 0 granted every time.
